// File: rtl/counter_run_ctrl.sv
//------------------------------------------------------------------------------
// counter_run_ctrl
//   Sequencer for a small up-counter.
//
//   A run works like this:
//     1. A start request in IDLE latches run_len.
//     2. The counter is reset for one cycle (CLR).
//     3. Enable is then held for exactly run_len cycles (RUN).
//     4. In CHECK, the counter value is compared with run_len mod 2^CNT_W.
//        CHECK also drives a one-cycle done pulse.
//
//   pass and the saturating tallies update on the clock edge that leaves CHECK.
//   They are therefore visible from the cycle after the done pulse.
//
//   Optional feature, selected with the macro ABORT_EN:
//     - Adds an abort input.
//     - Asserting abort in CLR or RUN ends the run early.
//     - An aborted run is recorded as a failed run.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module counter_run_ctrl #(
    parameter int CNT_W   = 4,
    parameter int LEN_W   = 8,
    parameter int TALLY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   run_len,
    input  logic [CNT_W-1:0]   cnt_value,
`ifdef ABORT_EN
    input  logic               abort,
`endif
    output logic               cnt_reset,
    output logic               cnt_enable,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [TALLY_W-1:0] runs_tally,
    output logic [TALLY_W-1:0] fail_tally
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLR   = 2'd1,
        S_RUN   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0]   LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]   LEN_ZERO  = '0;
    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               aborted_q, aborted_d;
    logic               pass_q, pass_d;
    logic [TALLY_W-1:0] runs_q, runs_d;
    logic [TALLY_W-1:0] fails_q, fails_d;

    logic               abort_w;
    logic [CNT_W-1:0]   expect_val;
    logic               match_w;

    // Without the abort feature, the early-exit path is tied off.
    // This guarantees that every accepted run completes.
`ifdef ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // The expected counter value is the run length reduced modulo 2^CNT_W.
    // The counter wraps, so a run of 20 on a 4-bit counter lands on 4.
    generate
        if (LEN_W >= CNT_W) begin : g_exp_trunc
            assign expect_val = len_q[CNT_W-1:0];
        end else begin : g_exp_ext
            assign expect_val = {{(CNT_W-LEN_W){1'b0}}, len_q};
        end
    endgenerate

    assign match_w = (cnt_value == expect_val);

    // State and result registers.
    // A synchronous reset abandons any run in flight and clears the history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
            pass_q    <= 1'b0;
            runs_q    <= '0;
            fails_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
            pass_q    <= pass_d;
            runs_q    <= runs_d;
            fails_q   <= fails_d;
        end
    end

    // Next-state logic, and result bookkeeping for each phase of a run.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        pass_d    = pass_q;
        runs_d    = runs_q;
        fails_d   = fails_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d     = run_len;
                    rem_d     = run_len;
                    aborted_d = 1'b0;
                    state_d   = S_CLR;
                end
            end

            S_CLR: begin
                if (abort_w) begin
                    aborted_d = 1'b1;
                    state_d   = S_CHECK;
                end else if (len_q != LEN_ZERO) begin
                    state_d   = S_RUN;
                end else begin
                    // A zero-length run has no enable cycles, so it goes straight to the compare.
                    state_d   = S_CHECK;
                end
            end

            S_RUN: begin
                rem_d = rem_q - LEN_ONE;
                if (abort_w) begin
                    aborted_d = 1'b1;
                    state_d   = S_CHECK;
                end else if (rem_q == LEN_ONE) begin
                    state_d   = S_CHECK;
                end
            end

            S_CHECK: begin
                // An aborted run never counts as a pass, whatever the counter shows.
                pass_d = match_w && !aborted_q;
                if (runs_q != TALLY_MAX) begin
                    runs_d = runs_q + TALLY_ONE;
                end
                if (!(match_w && !aborted_q) && (fails_q != TALLY_MAX)) begin
                    fails_d = fails_q + TALLY_ONE;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The counter controls and status flags are decoded from the state.
    // cnt_reset is active only in CLR, and cnt_enable only in RUN.
    // As a result, the two can never be high in the same cycle.
    // cnt_enable is also gated by abort, so the counter stops in the abort cycle itself.
    assign cnt_reset  = (state_q == S_CLR);
    assign cnt_enable = (state_q == S_RUN) && !abort_w;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_CHECK);
    assign pass       = pass_q;
    assign runs_tally = runs_q;
    assign fail_tally = fails_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
//------------------------------------------------------------------------------
// tb_counter_run_ctrl
//   Drives counter_run_ctrl together with a behavioural 4-bit counter.
//   The counter can be forced stuck at zero.
//
//   The reference model describes each run as a timeline of cycle offsets
//   from the accepting edge:
//     - offset 1         : counter reset
//     - offsets 2..1+N   : enable
//     - offset 2+N       : done
//   From that timeline the model derives every output value.
//
//   Tallies are narrowed to 4 bits so that saturation is reachable quickly.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_counter_run_ctrl;

    localparam int CNT_W   = 4;
    localparam int LEN_W   = 8;
    localparam int TALLY_W = 4;
    localparam int CMOD    = 1 << CNT_W;
    localparam int TMAX    = (1 << TALLY_W) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [LEN_W-1:0]   run_len = '0;
    logic               fault = 1'b0;
`ifdef ABORT_EN
    logic               abort = 1'b0;
`endif
    logic [CNT_W-1:0]   ref_cnt = '0;
    logic [CNT_W-1:0]   cnt_value;
    logic               cnt_reset, cnt_enable, busy, done, pass;
    logic [TALLY_W-1:0] runs_tally, fail_tally;

    int checks = 0;
    int failures = 0;
    int en_total = 0;
    int done_total = 0;

    // Reference model state.
    bit m_active = 1'b0;
    bit m_ab = 1'b0;
    bit m_pass = 1'b0;
    int m_off = 0;
    int m_chk = 0;
    int m_len = 0;
    int m_runs = 0;
    int m_fails = 0;

    always #5 clk = ~clk;

    counter_run_ctrl #(
        .CNT_W   (CNT_W),
        .LEN_W   (LEN_W),
        .TALLY_W (TALLY_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_len    (run_len),
        .cnt_value  (cnt_value),
`ifdef ABORT_EN
        .abort      (abort),
`endif
        .cnt_reset  (cnt_reset),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .runs_tally (runs_tally),
        .fail_tally (fail_tally)
    );

    // Controlled counter: synchronous reset and enable, wrapping at 2^CNT_W.
    always @(posedge clk) begin
        if (cnt_reset) begin
            ref_cnt <= '0;
        end else if (cnt_enable) begin
            ref_cnt <= CNT_W'(ref_cnt + 1);
        end
    end

    // A faulty counter is modelled as stuck at zero.
    assign cnt_value = fault ? '0 : ref_cnt;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Model: advance the run timeline on each edge.
    always @(posedge clk) begin
        bit ok;
        if (reset) begin
            m_active = 1'b0;
            m_pass   = 1'b0;
            m_runs   = 0;
            m_fails  = 0;
            m_len    = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1'b1;
                m_off    = 1;
                m_len    = int'(run_len);
                m_chk    = m_len + 2;
                m_ab     = 1'b0;
            end
        end else begin
`ifdef ABORT_EN
            if (abort && m_off < m_chk) begin
                m_chk = m_off + 1;
                m_ab  = 1'b1;
            end
`endif
            if (m_off == m_chk) begin
                // A healthy counter always shows len mod 2^CNT_W here.
                // A stuck counter shows 0 instead.
                ok = !m_ab && (fault ? ((m_len % CMOD) == 0) : 1'b1);
                m_pass = ok;
                if (m_runs < TMAX) m_runs++;
                if (!ok && m_fails < TMAX) m_fails++;
                m_active = 1'b0;
            end else begin
                m_off++;
            end
        end
    end

    // Compare all outputs against the model in the middle of every cycle.
    always @(negedge clk) begin
        bit e_rst, e_en, e_done;
        e_rst  = m_active && (m_off == 1);
        e_done = m_active && (m_off == m_chk);
        e_en   = m_active && (m_off > 1) && (m_off < m_chk);
`ifdef ABORT_EN
        if (abort) e_en = 1'b0;
`endif
        chk("busy",       int'(busy),       int'(m_active));
        chk("cnt_reset",  int'(cnt_reset),  int'(e_rst));
        chk("cnt_enable", int'(cnt_enable), int'(e_en));
        chk("done",       int'(done),       int'(e_done));
        chk("pass",       int'(pass),       int'(m_pass));
        chk("runs_tally", int'(runs_tally), m_runs);
        chk("fail_tally", int'(fail_tally), m_fails);
        if (e_done && !m_ab && !fault) begin
            chk("cnt_at_check", int'(cnt_value), m_len % CMOD);
        end
        if (cnt_enable) en_total++;
        if (done) begin
            done_total++;
            $display("run done: len=%0d cnt_value=%0d aborted=%0d faulty=%0d",
                     m_len, cnt_value, m_ab, fault);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (m_active && k < bound) begin
            step();
            k++;
        end
        chk("idle_timeout", int'(m_active), 0);
    endtask

    task automatic launch(input int len);
        start   = 1'b1;
        run_len = LEN_W'(len);
        step();
        start   = 1'b0;
        // Changing run_len after acceptance must not affect the run.
        run_len = LEN_W'($urandom_range(0, 255));
    endtask

    initial begin
        int e0;
        int d0;
        int f0;

        // Reset for two cycles.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_runs", int'(runs_tally), 0);
        chk("rst_pass", int'(pass), 0);

        // 1: run_len=10 -> ten enable cycles, one done pulse, pass.
        e0 = en_total;
        d0 = done_total;
        launch(10);
        wait_idle(100);
        chk("t1_enables", en_total - e0, 10);
        chk("t1_dones", done_total - d0, 1);
        chk("t1_pass", int'(pass), 1);
        chk("t1_runs", int'(runs_tally), 1);

        // 2: zero-length run -> no enable cycles, pass.
        e0 = en_total;
        launch(0);
        wait_idle(20);
        chk("t2_enables", en_total - e0, 0);
        chk("t2_pass", int'(pass), 1);
        chk("t2_runs", int'(runs_tally), 2);

        // 3: wrap-around at 20, first with a good counter, then with a stuck one.
        e0 = en_total;
        launch(20);
        wait_idle(100);
        chk("t3_enables", en_total - e0, 20);
        chk("t3_pass", int'(pass), 1);
        fault = 1'b1;
        launch(20);
        wait_idle(100);
        fault = 1'b0;
        chk("t3_fault_pass", int'(pass), 0);
        chk("t3_fault_tally", int'(fail_tally), 1);

        // 4: start pulses while busy are ignored.
        e0 = en_total;
        d0 = done_total;
        launch(10);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(100);
        chk("t4_enables", en_total - e0, 10);
        chk("t4_dones", done_total - d0, 1);

        // 4b: start held high through CHECK re-arms one cycle after the return to IDLE.
        e0 = en_total;
        start   = 1'b1;
        run_len = LEN_W'(3);
        step();
        run_len = LEN_W'(5);
        wait_idle(100);
        chk("t4_idle_gap", int'(busy), 0);
        step();
        chk("t4_rearm", int'(busy), 1);
        start = 1'b0;
        wait_idle(100);
        chk("t4_enables_both", en_total - e0, 8);

        // 5: reset mid-RUN aborts immediately, clears tallies, and gives no done pulse.
        launch(10);
        repeat (6) step();
        d0 = done_total;
        reset = 1'b1;
        step();
        chk("t5_busy", int'(busy), 0);
        chk("t5_runs", int'(runs_tally), 0);
        chk("t5_fails", int'(fail_tally), 0);
        chk("t5_pass", int'(pass), 0);
        reset = 1'b0;
        step();
        chk("t5_no_done", done_total - d0, 0);

`ifdef ABORT_EN
        // 6: abort in the third RUN cycle of a run of 10.
        e0 = en_total;
        f0 = int'(fail_tally);
        launch(10);
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t6_done", int'(done), 1);
        step();
        chk("t6_pass", int'(pass), 0);
        chk("t6_fail_inc", int'(fail_tally) - f0, 1);
        chk("t6_enables", en_total - e0, 2);
`endif

        // Saturation: seventeen failing runs drive both 4-bit tallies to all-ones.
        reset = 1'b1;
        step();
        reset = 1'b0;
        fault = 1'b1;
        for (int i = 0; i < 17; i++) begin
            launch(1);
            wait_idle(20);
        end
        fault = 1'b0;
        chk("sat_runs", int'(runs_tally), TMAX);
        chk("sat_fails", int'(fail_tally), TMAX);
        launch(2);
        wait_idle(20);
        chk("sat_hold", int'(runs_tally), TMAX);

        // Randomized runs with stray starts, occasional faults, aborts and resets.
        f0 = 0;
        for (int i = 0; i < 40; i++) begin
            fault = ($urandom_range(0, 5) == 0);
            launch(int'($urandom_range(0, 35)));
            while (m_active && f0 < 4000) begin
                start = ($urandom_range(0, 3) == 0);
`ifdef ABORT_EN
                abort = ($urandom_range(0, 15) == 0);
`endif
                reset = ($urandom_range(0, 199) == 0);
                step();
                f0++;
            end
            start = 1'b0;
            reset = 1'b0;
`ifdef ABORT_EN
            abort = 1'b0;
`endif
            step();
        end
        chk("rand_budget", int'(f0 >= 4000), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
